// File: rtl/deltann_pkg.sv
// -----------------------------------------------------------------------------
// deltann_pkg
//   Shared definitions for the output-stream reader: reader FSM state type,
//   output feature map geometry and the value widths on either side of the
//   requantizer.
//   OUT_BIN_LEN is the accumulator width held by the output buffer.
//   BIN_LEN is the width of the requantized values sent to the next layer.
// -----------------------------------------------------------------------------
package deltann_pkg;

  // Output feature map geometry
  localparam int OUTPUT_CHANNEL = 2;
  localparam int OUTPUT_HEIGHT  = 2;
  localparam int OUTPUT_WIDTH   = 4;

  // Value widths
  localparam int BIN_LEN        = 8;
  localparam int OUT_BIN_LEN    = 16;

  // Default number of values per output beat. It must divide OUTPUT_WIDTH.
  localparam int DEF_LANES      = 4;

  // Index widths. They are kept at least 1 bit wide so that a degenerate
  // dimension of size 1 still gives a legal port.
  localparam int OUTPUT_CHANNEL_LOG = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1;
  localparam int OUTPUT_ROW_LOG     = (OUTPUT_HEIGHT  > 1) ? $clog2(OUTPUT_HEIGHT)  : 1;
  localparam int OUTPUT_COL_LOG     = (OUTPUT_WIDTH   > 1) ? $clog2(OUTPUT_WIDTH)   : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } reader_state_t;

endpackage

// File: rtl/output_stream_reader_requant_sat.sv
// -----------------------------------------------------------------------------
// requant_sat
//   Combinational requantizer for one lane. It right-shifts an unsigned
//   accumulator value and clamps the result to the BIN_LEN range.
//   Ports:
//     v     in  OUT_BIN_LEN  accumulator value (unsigned)
//     shift in  SHIFT_W      right-shift amount
//     q     out BIN_LEN      requantized value
//     sat   out 1            high when the clamp was applied
// -----------------------------------------------------------------------------
module requant_sat
  import deltann_pkg::*;
#(
  parameter int SHIFT_W = 5
) (
  input  logic [OUT_BIN_LEN-1:0] v,
  input  logic [SHIFT_W-1:0]     shift,
  output logic [BIN_LEN-1:0]     q,
  output logic                   sat
);

  logic [OUT_BIN_LEN-1:0] shifted;

  // Shift and clamp. A shift of OUT_BIN_LEN or more shifts out every bit, so
  // the result is naturally zero.
  always_comb begin
    shifted = v >> shift;
    sat     = |shifted[OUT_BIN_LEN-1:BIN_LEN];
    if (sat) begin
      q = {BIN_LEN{1'b1}};
    end else begin
      q = shifted[BIN_LEN-1:0];
    end
  end

endmodule

// File: rtl/output_stream_reader.sv
// -----------------------------------------------------------------------------
// output_stream_reader
//   Read side of the output buffer. On start it walks the accumulated feature
//   map in channel -> row -> column-group order. It requantizes LANES values
//   per beat and presents each beat on a valid/ready stream. After the last
//   beat is accepted it pulses done and clear_req together for one cycle.
//   Ports:
//     clock, reset      rising-edge clock, asynchronous active-low reset
//     start             begin a drain (honoured only in IDLE)
//     shift             requantization shift, latched at start
//     buf_vals          whole output buffer, stable for the drain
//     out_valid/ready   stream handshake
//     out_data          LANES requantized values, lane 0 = lowest column
//     out_ch/row/col    position of the current beat (col = first column)
//     out_last          final beat of the map
//     busy              high in STREAM and DONE
//     done, clear_req   one-cycle pulse after the final beat is accepted
//     sat_count         saturated lanes in the current or last drain
// -----------------------------------------------------------------------------
module output_stream_reader
  import deltann_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int SHIFT_W  = 5,
  parameter int SATCNT_W = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [SHIFT_W-1:0]                    shift,
  input  logic [OUTPUT_CHANNEL-1:0][OUTPUT_HEIGHT-1:0][OUTPUT_WIDTH-1:0][OUT_BIN_LEN-1:0] buf_vals,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LANES-1:0][BIN_LEN-1:0]         out_data,
  output logic [OUTPUT_CHANNEL_LOG-1:0]         out_ch,
  output logic [OUTPUT_ROW_LOG-1:0]             out_row,
  output logic [OUTPUT_COL_LOG-1:0]             out_col,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  clear_req,
  output logic [SATCNT_W-1:0]                   sat_count
);

  localparam int CH_W  = OUTPUT_CHANNEL_LOG;
  localparam int ROW_W = OUTPUT_ROW_LOG;
  localparam int COL_W = OUTPUT_COL_LOG;
  localparam int CNT_W = $clog2(LANES + 1);

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(OUTPUT_CHANNEL - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUTPUT_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUTPUT_WIDTH - LANES);

  // Number of lanes flagged saturated in one beat
  function automatic logic [CNT_W-1:0] count_ones(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Accumulate into the saturation counter, sticking at all-ones
  function automatic logic [SATCNT_W-1:0] sat_add(input logic [SATCNT_W-1:0] a,
                                                   input logic [CNT_W-1:0]    n);
    logic [SATCNT_W:0] s;
    s = {1'b0, a} + (SATCNT_W + 1)'(n);
    if (s[SATCNT_W]) begin
      return {SATCNT_W{1'b1}};
    end else begin
      return s[SATCNT_W-1:0];
    end
  endfunction

  reader_state_t                 state_q, state_d;
  logic                          out_valid_q, out_valid_d;
  logic [LANES-1:0][BIN_LEN-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]               out_ch_q, out_ch_d;
  logic [ROW_W-1:0]              out_row_q, out_row_d;
  logic [COL_W-1:0]              out_col_q, out_col_d;
  logic                          out_last_q, out_last_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          clear_req_q, clear_req_d;
  logic [SATCNT_W-1:0]           sat_count_q, sat_count_d;
  logic [SHIFT_W-1:0]            shift_q, shift_d;

  // Position and shift of the beat about to be registered
  logic                          load_beat;
  logic [CH_W-1:0]               fetch_ch;
  logic [ROW_W-1:0]              fetch_row;
  logic [COL_W-1:0]              fetch_col;
  logic [SHIFT_W-1:0]            fetch_shift;
  logic [SATCNT_W-1:0]           sat_base;

  logic [LANES-1:0][BIN_LEN-1:0] lane_q;
  logic [LANES-1:0]              lane_sat;

  // One requantizer per lane, fed from the beat being fetched. The beat is
  // either the first beat on start or the successor on a handshake.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [COL_W-1:0] lane_col;
    assign lane_col = fetch_col + COL_W'(l);

    requant_sat #(
      .SHIFT_W (SHIFT_W)
    ) u_requant (
      .v     (buf_vals[fetch_ch][fetch_row][lane_col]),
      .shift (fetch_shift),
      .q     (lane_q[l]),
      .sat   (lane_sat[l])
    );
  end

  // Next-state logic: FSM transitions, index walk and beat loading
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    clear_req_d = 1'b0;
    sat_count_d = sat_count_q;
    shift_d     = shift_q;

    load_beat   = 1'b0;
    fetch_ch    = out_ch_q;
    fetch_row   = out_row_q;
    fetch_col   = out_col_q;
    fetch_shift = shift_q;
    sat_base    = sat_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          load_beat   = 1'b1;
          fetch_ch    = '0;
          fetch_row   = '0;
          fetch_col   = '0;
          // Use the live shift input for the first beat. The flop only
          // captures it at this same edge.
          fetch_shift = shift;
          shift_d     = shift;
          sat_base    = '0;
        end else begin
          state_d = IDLE;
        end
      end

      STREAM: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            clear_req_d = 1'b1;
          end else begin
            load_beat = 1'b1;
            if (out_col_q == LAST_COL) begin
              fetch_col = '0;
              if (out_row_q == LAST_ROW) begin
                fetch_row = '0;
                fetch_ch  = out_ch_q + CH_W'(1);
              end else begin
                fetch_row = out_row_q + ROW_W'(1);
              end
            end else begin
              fetch_col = out_col_q + COL_W'(LANES);
            end
          end
        end else begin
          // Stalled: every output holds its value
          state_d = STREAM;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    if (load_beat) begin
      out_data_d  = lane_q;
      out_ch_d    = fetch_ch;
      out_row_d   = fetch_row;
      out_col_d   = fetch_col;
      out_last_d  = (fetch_ch == LAST_CH) && (fetch_row == LAST_ROW) && (fetch_col == LAST_COL);
      sat_count_d = sat_add(sat_base, count_ones(lane_sat));
    end else begin
      out_data_d = out_data_d;
    end
  end

  // State and output register stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_req_q <= 1'b0;
      sat_count_q <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clear_req_q <= clear_req_d;
      sat_count_q <= sat_count_d;
      shift_q     <= shift_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign clear_req = clear_req_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_output_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_output_stream_reader
//   Directed bench for output_stream_reader on a 2x2x4 map with 4 lanes.
//   Inputs are driven on the falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_output_stream_reader;
  import deltann_pkg::*;

  localparam int L   = DEF_LANES;
  localparam int OC  = OUTPUT_CHANNEL;
  localparam int OH  = OUTPUT_HEIGHT;
  localparam int OW  = OUTPUT_WIDTH;
  localparam int GPR = OW / L;
  localparam int NB  = OC * OH * OW / L;

  logic                            clock = 1'b0;
  logic                            reset = 1'b0;
  logic                            start = 1'b0;
  logic [4:0]                      shift = 5'd0;
  logic [OC-1:0][OH-1:0][OW-1:0][OUT_BIN_LEN-1:0] buf_vals;
  logic                            out_valid;
  logic                            out_ready = 1'b0;
  logic [L-1:0][BIN_LEN-1:0]       out_data;
  logic [OUTPUT_CHANNEL_LOG-1:0]   out_ch;
  logic [OUTPUT_ROW_LOG-1:0]       out_row;
  logic [OUTPUT_COL_LOG-1:0]       out_col;
  logic                            out_last;
  logic                            busy;
  logic                            done;
  logic                            clear_req;
  logic [15:0]                     sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  output_stream_reader #(
    .LANES    (L),
    .SHIFT_W  (5),
    .SATCNT_W (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .shift     (shift),
    .buf_vals  (buf_vals),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .clear_req (clear_req),
    .sat_count (sat_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference requantized beat k under shift sh
  function automatic logic [31:0] model_data(input int k, input int sh);
    int c, r, w, q;
    logic [31:0] res;
    c = k / (OH * GPR);
    r = (k / GPR) % OH;
    w = (k % GPR) * L;
    res = 32'h0;
    for (int l = 0; l < L; l++) begin
      q = int'(buf_vals[c][r][w + l]) >> sh;
      if (q > 255) q = 255;
      res[l*8 +: 8] = 8'(q);
    end
    return res;
  endfunction

  // Reference count of saturated lanes over a whole drain
  function automatic int model_sat(input int sh);
    int n;
    n = 0;
    for (int c = 0; c < OC; c++)
      for (int r = 0; r < OH; r++)
        for (int w = 0; w < OW; w++)
          if ((int'(buf_vals[c][r][w]) >> sh) > 255) n++;
    return n;
  endfunction

  task automatic fill_index();
    for (int c = 0; c < OC; c++)
      for (int r = 0; r < OH; r++)
        for (int w = 0; w < OW; w++)
          buf_vals[c][r][w] = 16'(c * OH * OW + r * OW + w);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int c = 0; c < OC; c++)
      for (int r = 0; r < OH; r++)
        for (int w = 0; w < OW; w++)
          buf_vals[c][r][w] = v;
  endtask

  task automatic fill_random();
    for (int c = 0; c < OC; c++)
      for (int r = 0; r < OH; r++)
        for (int w = 0; w < OW; w++)
          buf_vals[c][r][w] = 16'($urandom_range(0, 1023));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_data"},  64'(out_data),  64'd0);
    check_eq({tag, "_ch"},    64'(out_ch),    64'd0);
    check_eq({tag, "_row"},   64'(out_row),   64'd0);
    check_eq({tag, "_col"},   64'(out_col),   64'd0);
    check_eq({tag, "_last"},  64'(out_last),  64'd0);
    check_eq({tag, "_busy"},  64'(busy),      64'd0);
    check_eq({tag, "_done"},  64'(done),      64'd0);
    check_eq({tag, "_clear"}, 64'(clear_req), 64'd0);
    check_eq({tag, "_sat"},   64'(sat_count), 64'd0);
  endtask

  // Run one drain from a falling edge. When started is set, the DUT is
  // already presenting beat 0. When hold is set, start stays high and the
  // task checks that a second drain begins only after DONE returns to IDLE.
  task automatic drain(input int sh, input bit rnd, input bit hold,
                       input bit started, input int exp_sat);
    int k, cyc;
    if (!started) begin
      start = 1'b1;
      shift = 5'(sh);
      @(negedge clock);
      start = hold;
      if (!hold) shift = ~5'(sh);
    end else begin
      start = 1'b0;
    end
    k = 0;
    cyc = 0;
    while (k < NB && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq("beat_valid", 64'(out_valid), 64'd1);
      check_eq("beat_busy",  64'(busy),      64'd1);
      check_eq("beat_data",  64'(out_data),  64'(model_data(k, sh)));
      check_eq("beat_ch",    64'(out_ch),    64'(k / (OH * GPR)));
      check_eq("beat_row",   64'(out_row),   64'((k / GPR) % OH));
      check_eq("beat_col",   64'(out_col),   64'((k % GPR) * L));
      check_eq("beat_last",  64'(out_last),  64'(k == NB - 1));
      check_eq("beat_nodone", 64'(done),     64'd0);
      if (out_ready) k++;
      @(negedge clock);
      cyc++;
    end
    check_eq("beats_seen", 64'(k), 64'(NB));
    out_ready = 1'b0;
    check_eq("done_pulse",  64'(done),      64'd1);
    check_eq("clear_pulse", 64'(clear_req), 64'd1);
    check_eq("done_valid",  64'(out_valid), 64'd0);
    check_eq("done_busy",   64'(busy),      64'd1);
    check_eq("sat_count",   64'(sat_count), 64'(exp_sat));
    @(negedge clock);
    check_eq("idle_done",  64'(done),      64'd0);
    check_eq("idle_clear", 64'(clear_req), 64'd0);
    check_eq("idle_busy",  64'(busy),      64'd0);
    check_eq("idle_valid", 64'(out_valid), 64'd0);
    check_eq("idle_sat",   64'(sat_count), 64'(exp_sat));
    if (hold) begin
      @(negedge clock);
      check_eq("restart_valid", 64'(out_valid), 64'd1);
      check_eq("restart_pos",   64'({out_ch, out_row, out_col}), 64'd0);
    end
  endtask

  initial begin
    fill_const(16'h0123);

    // Reset state
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    // Index data, shift 0: beats carry 0..15 in order
    fill_index();
    drain(0, 1'b0, 1'b0, 1'b0, 0);
    check_eq("t1_held_data", 64'(out_data), 64'h0F0E0D0C);
    check_eq("t1_held_pos",  64'({out_ch, out_row, out_col}), 64'({1'b1, 1'b1, 2'd0}));

    // Saturation: 0x3FF >> 1 clamps every lane, 0x3FF >> 2 is exactly 255
    fill_const(16'h03FF);
    drain(1, 1'b0, 1'b0, 1'b0, 16);
    check_eq("t2_data_sh1", 64'(out_data), 64'hFFFFFFFF);
    drain(2, 1'b0, 1'b0, 1'b0, 0);
    check_eq("t2_data_sh2", 64'(out_data), 64'hFFFFFFFF);

    // Huge shift: everything becomes zero
    fill_const(16'hFFFF);
    drain(31, 1'b0, 1'b0, 1'b0, 0);
    check_eq("t3_data_sh31", 64'(out_data), 64'h0);

    // Random data under random backpressure
    fill_random();
    drain(1, 1'b1, 1'b0, 1'b0, model_sat(1));
    fill_random();
    drain(0, 1'b1, 1'b0, 1'b0, model_sat(0));

    // start held through STREAM and DONE, then the follow-on drain
    fill_const(16'h03FF);
    drain(1, 1'b0, 1'b1, 1'b0, 16);
    drain(1, 1'b0, 1'b0, 1'b1, 16);

    // Reset mid-stream while beat 2 is presented
    fill_index();
    start = 1'b1;
    shift = 5'd0;
    @(negedge clock);
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_eq("mid_beat2_data", 64'(out_data), 64'h0B0A0908);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("post_reset_done",  64'(done),      64'd0);
      check_eq("post_reset_clear", 64'(clear_req), 64'd0);
      check_eq("post_reset_valid", 64'(out_valid), 64'd0);
    end
    drain(0, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
